// File: rtl/fc_out_layer_if.sv
// Streaming feature input, weight-ROM port, bias vector and neuron results of fc_out_layer.
// in_valid/in_ready: a sample transfers on a rising edge where both are 1; in_data must be held while in_valid=1 and in_ready=0.
interface fc_out_layer_if #(
    parameter int W      = 16,
    parameter int HEIGHT = 10,
    parameter int AW     = 6
);
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in_data;
    logic signed [W-1:0] bias         [0:HEIGHT-1];
    logic [AW-1:0]       w_addr;
    logic signed [W-1:0] w_data       [0:HEIGHT-1];
    logic signed [W-1:0] result_layer [0:HEIGHT-1];
    logic                out_valid;

    modport slave (
        input  in_valid, in_data, bias, w_data,
        output in_ready, w_addr, result_layer, out_valid
    );

    modport master (
        output in_valid, in_data, bias, w_data,
        input  in_ready, w_addr, result_layer, out_valid
    );
endinterface

// File: rtl/fc_out_layer.sv
// Fully-connected output layer: HEIGHT parallel fixed-point MACs over N_IN streamed features,
// bias preload, saturating rescale to W bits, one out_valid pulse per frame.
module fc_out_layer #(
    parameter int BITS_INT = 4,
    parameter int BITS_FRC = 12,
    parameter int HEIGHT   = 10,
    parameter int N_IN     = 64
) (
    input  logic          clk,
    input  logic          reset,
    fc_out_layer_if.slave bus,
    output logic [1:0]    o_dbg_state
);
    localparam int W     = BITS_INT + BITS_FRC;
    localparam int AW    = $clog2(N_IN);
    localparam int PW    = 2 * W;
    localparam int ACC_W = PW + AW + 1;

    localparam logic [AW:0] CNT_LAST = (AW + 1)'(N_IN - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W - W + 1){1'b0}}, {(W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W - W + 1){1'b1}}, {(W - 1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

    state_t                  r_state;
    logic [AW:0]             r_cnt;
    logic                    r_mac_en;
    logic signed [W-1:0]     r_in_data;
    logic signed [ACC_W-1:0] r_acc    [0:HEIGHT-1];
    logic signed [W-1:0]     r_result [0:HEIGHT-1];
    logic                    r_out_valid;

    logic                    w_ready;
    logic                    w_accept;
    logic signed [PW-1:0]    w_prod     [0:HEIGHT-1];
    logic signed [ACC_W-1:0] w_prod_ext [0:HEIGHT-1];
    logic signed [ACC_W-1:0] w_bias_ext [0:HEIGHT-1];

    function automatic logic signed [W-1:0] saturate(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] shifted;
        shifted = acc >>> BITS_FRC;
        if (shifted > SAT_MAX) begin
            return SAT_MAX[W-1:0];
        end else if (shifted < SAT_MIN) begin
            return SAT_MIN[W-1:0];
        end
        return shifted[W-1:0];
    endfunction

    assign w_ready           = reset && ((r_state == IDLE) || (r_state == ACCUM));
    assign w_accept          = w_ready && bus.in_valid;
    assign bus.in_ready      = w_ready;
    assign bus.w_addr        = r_cnt[AW-1:0];
    assign bus.out_valid     = r_out_valid;
    assign bus.result_layer  = r_result;
    assign o_dbg_state       = r_state;

    // The sample registered at acceptance meets its ROM row one edge later.
    always_comb begin
        for (int k = 0; k < HEIGHT; k++) begin
            w_prod[k]     = r_in_data * bus.w_data[k];
            w_prod_ext[k] = {{(ACC_W - PW){w_prod[k][PW-1]}}, w_prod[k]};
            w_bias_ext[k] = {{(ACC_W - W - BITS_FRC){bus.bias[k][W-1]}}, bus.bias[k], {BITS_FRC{1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_mac_en    <= 1'b0;
            r_in_data   <= '0;
            r_out_valid <= 1'b0;
            for (int k = 0; k < HEIGHT; k++) begin
                r_acc[k]    <= '0;
                r_result[k] <= '0;
            end
        end else begin
            r_out_valid <= 1'b0;
            r_mac_en    <= w_accept;
            if (w_accept) begin
                r_in_data <= bus.in_data;
            end
            for (int k = 0; k < HEIGHT; k++) begin
                if ((r_state == IDLE) && w_accept) begin
                    r_acc[k] <= w_bias_ext[k];
                end else if (r_mac_en) begin
                    r_acc[k] <= r_acc[k] + w_prod_ext[k];
                end
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_cnt   <= {{AW{1'b0}}, 1'b1};
                        r_state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CNT_LAST) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    r_cnt   <= '0;
                    r_state <= DONE;
                end
                DONE: begin
                    for (int k = 0; k < HEIGHT; k++) begin
                        r_result[k] <= saturate(r_acc[k]);
                    end
                    r_out_valid <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fc_out_layer.sv
// Directed and randomized frames for fc_out_layer, checked against an arithmetic reference of the layer.
module tb_fc_out_layer;
    localparam int BITS_INT = 4;
    localparam int BITS_FRC = 12;
    localparam int W        = 16;
    localparam int HEIGHT   = 10;
    localparam int N_IN     = 4;
    localparam int AW       = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    fc_out_layer_if #(.W(W), .HEIGHT(HEIGHT), .AW(AW)) bus ();

    fc_out_layer #(
        .BITS_INT(BITS_INT), .BITS_FRC(BITS_FRC), .HEIGHT(HEIGHT), .N_IN(N_IN)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .o_dbg_state(dbg_state)
    );

    logic signed [W-1:0] rom      [0:N_IN-1][0:HEIGHT-1];
    logic signed [W-1:0] xs       [0:N_IN-1];
    logic signed [W-1:0] bs       [0:HEIGHT-1];
    logic signed [W-1:0] exp_res  [0:HEIGHT-1];
    logic signed [W-1:0] prev_res [0:HEIGHT-1];

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int pulses = 0;
    int frames_done = 0;
    int last_accept = 0;
    int first_accept = 0;
    int prev_last = 0;

    // Synchronous weight ROM: row for w_addr appears one edge later.
    always @(posedge clk) begin
        for (int k = 0; k < HEIGHT; k++) bus.w_data[k] <= rom[bus.w_addr][k];
    end

    always @(posedge clk) begin
        cyc++;
        if (bus.out_valid === 1'b1) pulses++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic signed [W-1:0] ref_neuron(input int k);
        longint s;
        s = longint'(bs[k]) * 4096;
        for (int i = 0; i < N_IN; i++) s += longint'(xs[i]) * longint'(rom[i][k]);
        s = s >>> BITS_FRC;
        if (s > 32767) return 16'sh7FFF;
        if (s < -32768) return 16'sh8000;
        return s[W-1:0];
    endfunction

    function automatic logic signed [W-1:0] rnd();
        logic signed [W-1:0] v;
        v = W'($urandom);
        return v >>> $urandom_range(0, 4);
    endfunction

    task automatic set_rom(input logic signed [W-1:0] v);
        for (int i = 0; i < N_IN; i++)
            for (int k = 0; k < HEIGHT; k++) rom[i][k] = v;
    endtask

    task automatic set_xs(input logic signed [W-1:0] v);
        for (int i = 0; i < N_IN; i++) xs[i] = v;
    endtask

    task automatic set_bs(input logic signed [W-1:0] v);
        for (int k = 0; k < HEIGHT; k++) bs[k] = v;
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send_sample(input logic signed [W-1:0] x);
        int t;
        t = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = x;
        while (bus.in_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("accept_wait", bus.in_ready, 1);
        @(negedge clk);
        last_accept = cyc;
    endtask

    task automatic check_frame_end();
        check("pulse_count", pulses, frames_done);
        check("drain_valid", bus.out_valid, 0);
        check("drain_ready", bus.in_ready, 0);
        check("drain_state", dbg_state, 2);
        @(negedge clk);
        check("done_valid", bus.out_valid, 0);
        check("done_ready", bus.in_ready, 0);
        check("done_state", dbg_state, 3);
        for (int k = 0; k < HEIGHT; k++)
            check($sformatf("hold_result[%0d]", k), bus.result_layer[k], prev_res[k]);
        @(negedge clk);
        check("out_valid", bus.out_valid, 1);
        check("pulse_latency", cyc - last_accept, 2);
        check("idle_ready", bus.in_ready, 1);
        for (int k = 0; k < HEIGHT; k++)
            check($sformatf("result[%0d]", k), bus.result_layer[k], exp_res[k]);
        frames_done++;
        for (int k = 0; k < HEIGHT; k++) prev_res[k] = exp_res[k];
    endtask

    task automatic run_frame(input int gap, input bit mid_bias, input bit keep_valid);
        for (int k = 0; k < HEIGHT; k++) begin
            bus.bias[k] = bs[k];
            exp_res[k]  = ref_neuron(k);
        end
        for (int i = 0; i < N_IN; i++) begin
            send_sample(xs[i]);
            if (i == 0) first_accept = last_accept;
            if (i == 0 && mid_bias)
                for (int k = 0; k < HEIGHT; k++) bus.bias[k] = W'($urandom);
            if (i < N_IN - 1 && gap > 0) begin
                bus.in_valid = 1'b0;
                for (int g = 0; g < gap; g++) begin
                    check("gap_ready", bus.in_ready, 1);
                    @(negedge clk);
                end
            end
        end
        if (!keep_valid) bus.in_valid = 1'b0;
        check_frame_end();
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        for (int k = 0; k < HEIGHT; k++) begin
            bus.bias[k] = '0;
            prev_res[k] = '0;
        end
        set_rom(16'sh0000);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", bus.in_ready, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_state", dbg_state, 0);
        for (int k = 0; k < HEIGHT; k++)
            check($sformatf("rst_result[%0d]", k), bus.result_layer[k], 0);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_ready", bus.in_ready, 1);

        // All weights 1.0, samples 0.5 -> 2.0 on every neuron
        set_rom(16'sh1000); set_xs(16'sh0800); set_bs(16'sh0000);
        run_frame(0, 0, 0);

        // Zero weights, only bias[3] = 1.0
        set_rom(16'sh0000); set_bs(16'sh0000); bs[3] = 16'sh1000;
        run_frame(0, 0, 0);

        // Positive and negative saturation
        set_rom(16'sh7000); set_xs(16'sh7000); set_bs(16'sh0000);
        run_frame(0, 0, 0);
        set_rom(-16'sh7000);
        run_frame(0, 0, 0);

        // Gapped frame: 3 idle cycles between samples
        set_rom(16'sh1000); set_xs(16'sh0800); set_bs(16'sh0000);
        run_frame(3, 0, 0);

        // Reset one cycle after the second sample, then a fresh frame
        set_rom(16'sh1000);
        send_sample(16'sh0800);
        send_sample(16'sh0800);
        bus.in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_ready", bus.in_ready, 0);
        check("abort_valid", bus.out_valid, 0);
        check("abort_result0", bus.result_layer[0], 0);
        reset = 1'b1;
        for (int k = 0; k < HEIGHT; k++) prev_res[k] = '0;
        @(negedge clk);
        set_rom(16'sh0000); set_xs(16'sh0800); set_bs(16'sh0000); bs[3] = 16'sh1000;
        run_frame(0, 0, 0);

        // Back-to-back frames with in_valid held high through DRAIN/DONE
        set_rom(16'sh1000); set_xs(16'sh0800); set_bs(16'sh0000);
        run_frame(0, 0, 1);
        prev_last = last_accept;
        set_rom(16'sh0000); set_bs(16'sh0000); bs[3] = 16'sh1000;
        run_frame(0, 0, 0);
        check("b2b_spacing", first_accept - prev_last, 3);

        // Reset landing on the DONE cycle suppresses the pulse
        set_rom(16'sh1000); set_xs(16'sh0800); set_bs(16'sh0000);
        for (int k = 0; k < HEIGHT; k++) bus.bias[k] = bs[k];
        for (int i = 0; i < N_IN; i++) send_sample(xs[i]);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_done_state", dbg_state, 3);
        reset = 1'b0;
        @(negedge clk);
        check("rst_done_valid", bus.out_valid, 0);
        check("rst_done_result", bus.result_layer[1], 0);
        reset = 1'b1;
        for (int k = 0; k < HEIGHT; k++) prev_res[k] = '0;
        repeat (2) @(negedge clk);
        check("rst_done_pulses", pulses, frames_done);

        // Randomized frames with gaps and bias changes after the first sample
        repeat (8) begin
            for (int i = 0; i < N_IN; i++) begin
                xs[i] = rnd();
                for (int k = 0; k < HEIGHT; k++) rom[i][k] = rnd();
            end
            for (int k = 0; k < HEIGHT; k++) bs[k] = rnd();
            run_frame($urandom_range(0, 2), 1'b1, 1'b0);
        end

        repeat (2) @(negedge clk);
        check("final_pulses", pulses, frames_done);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
